// File: rtl/nw_cell_scorer.sv
// nw_cell_scorer: one Needleman-Wunsch cell, three candidates over three
// phase cycles. in_valid/in_ready operands in; out_valid/out_ready cell_score,dir out.
module nw_cell_scorer #(
  parameter int W        = 8,
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int GAP      = -2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] diag_score,
  input  logic [W-1:0] up_score,
  input  logic [W-1:0] left_score,
  input  logic [1:0]   char_a,
  input  logic [1:0]   char_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] cell_score,
  output logic [1:0]   dir,
  output logic [1:0]   phase
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  localparam logic signed [W:0] MATCH_X = MATCH[W:0];
  localparam logic signed [W:0] MISM_X  = MISMATCH[W:0];
  localparam logic signed [W:0] GAP_X   = GAP[W:0];

  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  state_t state_q, state_d;
  logic [1:0] ph_q;

  logic signed [W-1:0] diag_q, up_q, left_q;
  logic [1:0] a_q, b_q;

  logic signed [W-1:0] best_q;
  logic [1:0]          bdir_q;
  logic signed [W-1:0] cell_q;
  logic [1:0]          dir_q;

  logic signed [W-1:0] opnd;
  logic signed [W:0]   addend;
  logic signed [W:0]   sum;
  logic signed [W-1:0] cand;
  logic                better;

  // One shared adder; the phase picks the operand and the addend.
  always_comb begin
    opnd   = left_q;
    addend = GAP_X;
    unique case (ph_q)
      2'd0: begin
        opnd   = diag_q;
        addend = (a_q == b_q) ? MATCH_X : MISM_X;
      end
      2'd1: opnd = up_q;
      default: opnd = left_q;
    endcase
    sum = {opnd[W-1], opnd} + addend;
    // Sign bits disagree only on overflow: clamp instead of wrapping.
    if (sum[W] != sum[W-1])
      cand = sum[W] ? SMIN : SMAX;
    else
      cand = sum[W-1:0];
    // Strict compare keeps the earlier candidate on ties.
    better = cand > best_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = EVAL;
      EVAL: if (ph_q == 2'd2) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= 2'd0;
      diag_q  <= '0;
      up_q    <= '0;
      left_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      best_q  <= '0;
      bdir_q  <= 2'b00;
      cell_q  <= '0;
      dir_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        diag_q <= diag_score;
        up_q   <= up_score;
        left_q <= left_score;
        a_q    <= char_a;
        b_q    <= char_b;
        ph_q   <= 2'd0;
      end
      if (state_q == EVAL) begin
        unique case (ph_q)
          2'd0: begin
            best_q <= cand;
            bdir_q <= 2'b00;
            ph_q   <= 2'd1;
          end
          2'd1: begin
            if (better) begin
              best_q <= cand;
              bdir_q <= 2'b01;
            end
            ph_q <= 2'd2;
          end
          default: begin
            cell_q <= better ? cand : best_q;
            dir_q  <= better ? 2'b10 : bdir_q;
            ph_q   <= 2'd0;
          end
        endcase
      end
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign cell_score = cell_q;
  assign dir        = dir_q;
  assign phase      = (state_q == EVAL) ? ph_q : 2'd0;

endmodule

// File: tb/tb_nw_cell_scorer.sv
// tb_nw_cell_scorer: directed and random cells vs. an arithmetic model
// of the cell recurrence (max of three clamped candidates, diag>up>left).
module tb_nw_cell_scorer;

  localparam int W  = 8;
  localparam int HI = (1 << (W - 1)) - 1;
  localparam int LO = -(1 << (W - 1));

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] diag_score;
  logic [W-1:0] up_score;
  logic [W-1:0] left_score;
  logic [1:0]   char_a;
  logic [1:0]   char_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] cell_score;
  logic [1:0]   dir;
  logic [1:0]   phase;

  int n_cmp;
  int n_err;
  int prev_score;
  int prev_dir;

  nw_cell_scorer #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .diag_score (diag_score),
    .up_score   (up_score),
    .left_score (left_score),
    .char_a     (char_a),
    .char_b     (char_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cell_score (cell_score),
    .dir        (dir),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x);
    if (x > HI) return HI;
    if (x < LO) return LO;
    return x;
  endfunction

  function automatic void ref_cell(input int d, input int u, input int l,
                                   input int a, input int b,
                                   output int s, output int dr);
    int c [3];
    c[0] = sat(d + ((a == b) ? 1 : -1));
    c[1] = sat(u - 2);
    c[2] = sat(l - 2);
    s  = c[0];
    dr = 0;
    for (int k = 1; k < 3; k++)
      if (c[k] > s) begin
        s  = c[k];
        dr = k;
      end
  endfunction

  function automatic int rnd_s();
    logic signed [W-1:0] v;
    v = W'($urandom);
    return int'(v);
  endfunction

  task automatic drive(input int d, input int u, input int l,
                       input int a, input int b);
    diag_score = d[W-1:0];
    up_score   = u[W-1:0];
    left_score = l[W-1:0];
    char_a     = a[1:0];
    char_b     = b[1:0];
  endtask

  task automatic scramble();
    drive(rnd_s(), rnd_s(), rnd_s(), $urandom_range(0, 3),
          $urandom_range(0, 3));
  endtask

  // Called just after the accept edge; walks E1..E3.
  task automatic expect_eval(input int es, input int ed);
    chk("eval_ph0", phase, 0);
    chk("eval_nordy", in_ready, 0);
    chk("eval_nov0", out_valid, 0);
    chk("eval_hold0", $signed(cell_score), prev_score);
    tick();
    chk("eval_ph1", phase, 1);
    tick();
    chk("eval_ph2", phase, 2);
    chk("eval_nov2", out_valid, 0);
    chk("eval_hold2", $signed(cell_score), prev_score);
    tick();
    chk("done_valid", out_valid, 1);
    chk("done_ph", phase, 0);
    chk("done_score", $signed(cell_score), es);
    chk("done_dir", dir, ed);
    prev_score = es;
    prev_dir   = ed;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_nov", out_valid, 0);
    chk("rel_rdy", in_ready, 1);
    chk("rel_score", $signed(cell_score), prev_score);
    chk("rel_dir", dir, prev_dir);
  endtask

  task automatic do_cell(input int d, input int u, input int l,
                         input int a, input int b,
                         input int es, input int ed, input int stall);
    chk("idle_rdy", in_ready, 1);
    drive(d, u, l, a, b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    scramble();
    expect_eval(es, ed);
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_score", $signed(cell_score), es);
    end
    release_out();
  endtask

  initial begin
    int s, dr, d, u, l, a, b;
    n_cmp = 0;
    n_err = 0;
    prev_score = 0;
    prev_dir = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rdy", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_score", $signed(cell_score), 0);
    chk("rst_dir", dir, 0);
    chk("rst_ph", phase, 0);

    do_cell(3, 4, 2, 0, 0, 4, 0, 0);
    do_cell(0, 1, 5, 1, 2, 3, 2, 0);
    do_cell(1, 4, 4, 2, 2, 2, 0, 1);
    do_cell(-128, -127, -128, 0, 1, -128, 0, 0);
    do_cell(127, 127, 127, 3, 3, 127, 0, 0);

    // Backpressure with a second set waiting on in_valid.
    drive(3, 4, 2, 0, 0);
    in_valid = 1'b1;
    tick();
    drive(0, 1, 5, 1, 2);
    expect_eval(4, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_rdy", in_ready, 0);
      chk("bp_score", $signed(cell_score), 4);
      chk("bp_dir", dir, 0);
    end
    release_out();
    tick();
    in_valid = 1'b0;
    expect_eval(3, 2);
    release_out();

    // Reset during phase 1.
    drive(10, 20, 30, 1, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mr_ph1", phase, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_rdy", in_ready, 1);
    chk("mr_ov", out_valid, 0);
    chk("mr_score", $signed(cell_score), 0);
    chk("mr_dir", dir, 0);
    chk("mr_ph", phase, 0);
    prev_score = 0;
    prev_dir = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_nostale", out_valid, 0);
    end

    for (int n = 0; n < 40; n++) begin
      d = rnd_s();
      u = rnd_s();
      l = rnd_s();
      a = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      if (n % 8 == 0) d = (n % 16 == 0) ? HI : LO;
      ref_cell(d, u, l, a, b, s, dr);
      do_cell(d, u, l, a, b, s, dr, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nw_cell_scorer.md
# nw_cell_scorer

Sequential score-evaluation stage for one Needleman-Wunsch matrix cell. It accepts the three neighbour scores (diagonal, up, left) and the two residue codes for the cell. It then evaluates the three candidate scores over three consecutive phase cycles, one candidate per cycle, using an internal 0→1→2 phase counter. It returns the cell score and the traceback direction through a valid/ready handshake to the matrix-fill controller.

## Interface
Parameters:
- W, 8: score width, signed two's complement.
- MATCH, 1: signed reward added to the diagonal score when residues are equal.
- MISMATCH, -1: signed penalty added to the diagonal score when residues differ.
- GAP, -2: signed penalty added to the up and left scores.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept operands (high only in IDLE).
- diag_score  in  W  signed score of cell (i-1,j-1).
- up_score  in  W  signed score of cell (i-1,j).
- left_score  in  W  signed score of cell (i,j-1).
- char_a  in  2  residue code of sequence A at i.
- char_b  in  2  residue code of sequence B at j.
- out_valid  out  1  result present (high only in DONE).
- out_ready  in  1  consumer takes result.
- cell_score  out  W  signed max of the three candidates.
- dir  out  2  traceback: 00 diag, 01 up, 10 left; 11 never produced.
- phase  out  2  current evaluation phase (0,1,2); 0 outside EVAL.

## Operation
- States: IDLE, EVAL, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch all five operands and go to EVAL with phase=0.
- EVAL, phase 0: best_score = sat(diag_score + (char_a==char_b ? MATCH : MISMATCH)); best_dir=00; phase→1.
- EVAL, phase 1: cand = sat(up_score + GAP); if cand > best_score (strict), best_score=cand and best_dir=01; phase→2.
- EVAL, phase 2: cand = sat(left_score + GAP); if cand > best_score (strict), replace with dir 10. Then phase→0, state→DONE.
- DONE:
  - out_valid=1; cell_score and dir are stable.
  - On an edge with out_ready=1, go to IDLE.
- Tie-break priority: diag > up > left. This follows from the strict comparison.
- Arithmetic:
  - Each addition is computed in W+1 bits.
  - The result saturates to [-2^(W-1), 2^(W-1)-1]; it never wraps.
- Operand inputs are ignored outside IDLE; the latched copies are used throughout.
- in_valid while in EVAL/DONE is not accepted; the upstream source holds it.
- out_ready while not in DONE has no effect.
- Reset values:
  - state=IDLE, phase=0, in_ready=1 (follows state), out_valid=0, cell_score=0, dir=00.
  - All latched operands are 0.
- Reset mid-operation (EVAL or DONE):
  - Returns to IDLE at that edge and discards the in-flight cell.
  - No out_valid is produced for it.

## Timing
- Accept edge E0: the edge where IDLE and in_valid=1.
- Phase 0 is evaluated at E1, phase 1 at E2, phase 2 at E3.
- out_valid is high from after E3 until the edge with out_ready=1.
- Latency: 3 cycles from accept edge to out_valid.
- Minimum throughput: one cell per 5 cycles (1 IDLE + 3 EVAL + 1 DONE with out_ready held high).
- in_ready rises the cycle after the DONE handshake edge.
- phase output equals the phase being evaluated in the current cycle.
- cell_score/dir are registered and change only at the E3 edge or at reset.
- rst dominates every other input on the same edge.

## Test plan
- Match, diag wins (W=8, default parameters):
  - Stimulus: diag=3, up=4, left=2, char_a=char_b=0.
  - Required: candidates 4/2/0, so cell_score=4, dir=00; out_valid exactly 3 cycles after accept; phase seen as 0,1,2.
- Left wins on mismatch:
  - Stimulus: diag=0, up=1, left=5, char_a=1, char_b=2.
  - Required: candidates -1/-1/3, so cell_score=3, dir=10.
- Tie-break:
  - Stimulus: diag=1 (match), up=4, left=4.
  - Required: all candidates 2, so cell_score=2, dir=00.
- Saturation:
  - Stimulus: diag=-128 (mismatch), up=-127, left=-128.
  - Required: all candidates saturate to -128, so cell_score=-128, dir=00, with no wrap to positive.
- Backpressure and back-to-back:
  - Stimulus: hold out_ready=0 for 4 cycles after out_valid rises, with a second operand set waiting on in_valid.
  - Required: result stable, in_ready=0 throughout. After release, in_ready=1 next cycle and the second cell is accepted; results are in order.
- Reset mid-EVAL:
  - Stimulus: assert rst for one cycle during phase 1.
  - Required: next cycle IDLE, in_ready=1, out_valid=0, cell_score=0, dir=00, phase=0, and no stale result ever emitted.
